// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - multi-channel programmable clock divider with glitch-free reprogramming
module prog_clock_divider #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 28,
  parameter int DEFAULT_HALF = 25000000,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_data,
  output logic [CHANNELS-1:0] div_clk,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pend
);

  localparam logic [CNT_W-1:0] DEF_H    = CNT_W'(DEFAULT_HALF);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

  logic [1:0] rst_sync_q;
  logic       active;

  logic [CNT_W-1:0] h_q   [CHANNELS];
  logic [CNT_W-1:0] h_d   [CHANNELS];
  logic [CNT_W-1:0] p_q   [CHANNELS];
  logic [CNT_W-1:0] p_d   [CHANNELS];
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];

  logic [CHANNELS-1:0] div_q, div_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] idle_w;
  logic [CHANNELS-1:0] hit_w;
  logic [CHANNELS-1:0] wrap_w;
  logic                wr_valid;

  // Two-stage release synchroniser: assert is immediate, release follows clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign active   = rst_sync_q[1];
  assign wr_valid = wr_en && ({1'b0, wr_ch} < CH_LIMIT);

  // Per-channel status: parked/disabled, targeted by the write port, last cycle of a level.
  always_comb begin
    idle_w = '0;
    hit_w  = '0;
    wrap_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idle_w[i] = !en[i] || (h_q[i] == '0);
      hit_w[i]  = wr_valid && (wr_ch == CH_W'(i));
      wrap_w[i] = (cnt_q[i] == (h_q[i] - CNT_W'(1)));
    end
  end

  // Next-state: hold in reset values until released, then park/realign/toggle/count,
  // swapping in a pending half-period only at a level boundary or while parked.
  always_comb begin
    div_d  = div_q;
    tick_d = '0;
    pend_d = pend_q;
    for (int i = 0; i < CHANNELS; i++) begin
      h_d[i]   = h_q[i];
      p_d[i]   = p_q[i];
      cnt_d[i] = cnt_q[i];
      if (!active) begin
        h_d[i]    = DEF_H;
        p_d[i]    = DEF_H;
        cnt_d[i]  = '0;
        div_d[i]  = 1'b0;
        pend_d[i] = 1'b0;
      end else begin
        if (idle_w[i]) begin
          cnt_d[i] = '0;
          div_d[i] = 1'b0;
          if (pend_q[i]) begin
            h_d[i]    = p_q[i];
            pend_d[i] = 1'b0;
          end
        end else if (sync) begin
          cnt_d[i] = '0;
          div_d[i] = 1'b0;
        end else if (wrap_w[i]) begin
          cnt_d[i]  = '0;
          div_d[i]  = !div_q[i];
          tick_d[i] = !div_q[i];
          if (pend_q[i]) begin
            h_d[i]    = p_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        // A write in the same cycle as an application is kept for the next boundary.
        if (hit_w[i]) begin
          p_d[i]    = wr_data;
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  // Channel state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        h_q[i]   <= DEF_H;
        p_q[i]   <= DEF_H;
        cnt_q[i] <= '0;
      end
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      for (int i = 0; i < CHANNELS; i++) begin
        h_q[i]   <= h_d[i];
        p_q[i]   <= p_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign div_clk = div_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - scoreboard bench for prog_clock_divider
module tb_prog_clock_divider;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int DEF = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '0;
  logic          sync = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [W-1:0]  wr_data = '0;
  logic [CH-1:0] div_clk, tick, pend;

  prog_clock_divider #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_HALF(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .div_clk(div_clk), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] dv;
    logic [CH-1:0] tk;
    logic [CH-1:0] pd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: each level lasts H cycles; age counts cycles spent in the current level.
  int m_h[CH], m_p[CH], m_age[CH];
  bit m_lvl[CH], m_tick[CH], m_pend[CH];
  int m_rel;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_h[i] = DEF; m_p[i] = DEF; m_age[i] = 0;
      m_lvl[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
    end
    m_rel = 0;
  endfunction

  function automatic void model_edge();
    exp_t e;
    if (!rst_n) begin
      model_reset();
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit hit;
        hit = wr_en && (int'(wr_ch) == i);
        m_tick[i] = 0;
        if (!en[i] || m_h[i] == 0) begin
          m_lvl[i] = 0; m_age[i] = 0;
          if (m_pend[i]) begin m_h[i] = m_p[i]; m_pend[i] = 0; end
        end else if (sync) begin
          m_lvl[i] = 0; m_age[i] = 0;
        end else if (m_age[i] + 1 == m_h[i]) begin
          m_lvl[i] = !m_lvl[i]; m_tick[i] = m_lvl[i]; m_age[i] = 0;
          if (m_pend[i]) begin m_h[i] = m_p[i]; m_pend[i] = 0; end
        end else begin
          m_age[i]++;
        end
        if (hit) begin m_p[i] = int'(wr_data); m_pend[i] = 1; end
      end
    end
    for (int i = 0; i < CH; i++) begin
      e.dv[i] = m_lvl[i]; e.tk[i] = m_tick[i]; e.pd[i] = m_pend[i];
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: after every rising edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (div_clk !== e.dv) begin
          errors++;
          $display("FAIL div_clk cycle %0d: got %b expected %b", cyc, div_clk, e.dv);
        end
        checks++;
        if (tick !== e.tk) begin
          errors++;
          $display("FAIL tick cycle %0d: got %b expected %b", cyc, tick, e.tk);
        end
        checks++;
        if (pend !== e.pd) begin
          errors++;
          $display("FAIL pend cycle %0d: got %b expected %b", cyc, pend, e.pd);
        end
      end
    end
  end

  task automatic drive(input logic [CH-1:0] e, input logic s, input logic we,
                       input logic [1:0] ch, input logic [W-1:0] d);
    @(negedge clk);
    en = e; sync = s; wr_en = we; wr_ch = ch; wr_data = d;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en = 4'hF; sync = 1'b0; wr_en = 1'b0;
    model_edge();
  endtask

  // Reset asserted between edges: outputs must clear without waiting for clk.
  task automatic async_reset();
    @(negedge clk);
    en = 4'hF; sync = 1'b0; wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (div_clk !== 4'h0 || tick !== 4'h0 || pend !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: got div=%b tick=%b pend=%b expected all 0", div_clk, tick, pend);
    end
    model_reset();
    model_edge();
  endtask

  task automatic wait_toggle(input int ch);
    for (int k = 0; k < 40 && !(m_age[ch] + 1 == m_h[ch] && m_h[ch] > 0); k++) idle(1);
  endtask

  initial begin
    model_reset();
    // Scenario 1: reset, release with all channels enabled.
    for (int k = 0; k < 3; k++) drive(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
    release_reset();
    idle(20);
    // Scenario 2: reprogram ch1 during its high level.
    for (int k = 0; k < 20 && !(m_lvl[1] && m_age[1] == 1); k++) idle(1);
    drive(4'hF, 1'b0, 1'b1, 2'd1, 8'd5);
    idle(25);
    // Scenario 3: last write wins, then a write coincident with a toggle.
    drive(4'hF, 1'b0, 1'b1, 2'd2, 8'd2);
    drive(4'hF, 1'b0, 1'b1, 2'd2, 8'd7);
    idle(20);
    wait_toggle(2);
    drive(4'hF, 1'b0, 1'b1, 2'd2, 8'd2);
    idle(25);
    // Scenario 4: park ch3, then restart it with H=4.
    drive(4'hF, 1'b0, 1'b1, 2'd3, 8'd0);
    idle(12);
    drive(4'hF, 1'b0, 1'b1, 2'd3, 8'd4);
    idle(15);
    // Scenario 5: mixed half-periods, sync coincident with a ch0 toggle.
    drive(4'hF, 1'b0, 1'b1, 2'd0, 8'd4);
    idle(15);
    wait_toggle(0);
    drive(4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
    idle(20);
    // Disable/enable individual channels.
    for (int k = 0; k < 4; k++) drive(4'b1010, 1'b0, 1'b0, 2'd0, 8'd0);
    idle(12);
    // Scenario 6: reset while a write is pending.
    drive(4'hF, 1'b0, 1'b1, 2'd1, 8'd6);
    async_reset();
    drive(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
    release_reset();
    idle(15);
    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [CH-1:0] e;
      e = ($urandom_range(0, 19) == 0) ? CH'($urandom_range(0, 15)) : 4'hF;
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        release_reset();
      end else begin
        drive(e, ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
              2'($urandom_range(0, 3)), W'($urandom_range(0, 7)));
      end
    end
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
